// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: one-entry holding buffer feeding an MSB-first
// shifter that repeats each pattern reps+1 times and pulses done at job end.
module seq_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic [CW-1:0]    nbits_i,
    input  logic [CW-1:0]    reps_i,
    output logic             ready_o,
    output logic             x_o,
    output logic             xvalid_o,
    output logic             done_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q;
    logic             hold_full_q;
    logic [WIDTH-1:0] hold_pat_q;
    logic [CW-1:0]    hold_nb_q;
    logic [CW-1:0]    hold_reps_q;
    logic [WIDTH-1:0] pat_q;
    logic [WIDTH-1:0] sh_q;
    logic [CW-1:0]    nb_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    rep_q;
    logic             done_q;

    logic [CW-1:0]    nb_eff;
    logic [WIDTH-1:0] din_aligned;
    logic             accept;
    logic             last_bit;
    logic             take;

    always_comb begin
        nb_eff = nbits_i;
        if (nbits_i == '0 || nbits_i > CW'(WIDTH)) nb_eff = CW'(WIDTH);
    end

    // Patterns are stored left-aligned so the shifter always emits bit WIDTH-1.
    assign din_aligned = din_i << (CW'(WIDTH) - nb_eff);
    assign accept      = load_i && !hold_full_q;
    assign last_bit    = (cnt_q == '0) && (rep_q == '0);
    assign take        = hold_full_q && (state_q == IDLE || last_bit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            hold_pat_q  <= '0;
            hold_nb_q   <= '0;
            hold_reps_q <= '0;
            pat_q       <= '0;
            sh_q        <= '0;
            nb_q        <= '0;
            cnt_q       <= '0;
            rep_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                hold_full_q <= 1'b1;
                hold_pat_q  <= din_aligned;
                hold_nb_q   <= nb_eff;
                hold_reps_q <= reps_i;
            end
            if (state_q == SHIFT && last_bit) done_q <= 1'b1;
            if (take) begin
                hold_full_q <= 1'b0;
                pat_q       <= hold_pat_q;
                sh_q        <= hold_pat_q;
                nb_q        <= hold_nb_q;
                cnt_q       <= hold_nb_q - CW'(1);
                rep_q       <= hold_reps_q;
                state_q     <= SHIFT;
            end else if (state_q == SHIFT) begin
                if (cnt_q != '0) begin
                    sh_q  <= sh_q << 1;
                    cnt_q <= cnt_q - CW'(1);
                end else if (rep_q != '0) begin
                    rep_q <= rep_q - CW'(1);
                    sh_q  <= pat_q;
                    cnt_q <= nb_q - CW'(1);
                end else begin
                    state_q <= IDLE;
                    sh_q    <= '0;
                end
            end
        end
    end

    assign ready_o  = !hold_full_q;
    assign xvalid_o = (state_q == SHIFT);
    assign x_o      = xvalid_o & sh_q[WIDTH-1];
    assign done_o   = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: a job-level model predicts the bit
// stream, buffer occupancy and done pulses; a negedge monitor checks them.
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_i = 1'b0;
    logic [7:0] din_i = '0;
    logic [3:0] nbits_i = '0;
    logic [3:0] reps_i = '0;
    logic       ready_o, x_o, xvalid_o, done_o;

    int vectors = 0;
    int miscompares = 0;

    bit exp_bits[$];
    int job_len[$];
    bit m_hold = 1'b0;
    int m_hold_len = 0;
    int m_rem = 0;

    int bits_cnt = 0;
    bit done_pend = 1'b0;

    seq_pattern_gen #(.WIDTH(8), .CW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load_i),
        .din_i    (din_i),
        .nbits_i  (nbits_i),
        .reps_i   (reps_i),
        .ready_o  (ready_o),
        .x_o      (x_o),
        .xvalid_o (xvalid_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a job is nb*(reps+1) bits; the buffer empties when the active
    // job has at most its final bit left.
    task automatic model_step();
        bit acc;
        int nbe;
        acc = load_i && !m_hold;
        if (m_hold && m_rem <= 1) begin
            m_rem  = m_hold_len;
            m_hold = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
        end
        if (acc) begin
            nbe = (nbits_i == 0 || nbits_i > 8) ? 8 : int'(nbits_i);
            for (int r = 0; r <= int'(reps_i); r++)
                for (int i = nbe - 1; i >= 0; i--)
                    exp_bits.push_back(din_i[i]);
            m_hold_len = nbe * (int'(reps_i) + 1);
            job_len.push_back(m_hold_len);
            m_hold = 1'b1;
        end
    endtask

    task automatic cycle(input bit ld, input logic [7:0] d, input logic [3:0] nb,
                         input logic [3:0] rp);
        load_i  = ld;
        din_i   = d;
        nbits_i = nb;
        reps_i  = rp;
        @(posedge clk);
        model_step();
        @(negedge clk);
        load_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 4'd0, 4'd0);
    endtask

    task automatic model_reset();
        exp_bits.delete();
        job_len.delete();
        m_hold = 1'b0;
        m_hold_len = 0;
        m_rem = 0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            bits_cnt  = 0;
            done_pend = 1'b0;
        end else begin
            check("ready", ready_o, !m_hold);
            check("xvalid", xvalid_o, m_rem != 0);
            check("done", done_o, done_pend);
            done_pend = 1'b0;
            if (xvalid_o) begin
                if (exp_bits.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL x_unexpected: got bit %0b expected no bit at %0t", x_o, $time);
                end else begin
                    check("x", x_o, exp_bits.pop_front());
                    bits_cnt++;
                    if (job_len.size() > 0 && bits_cnt == job_len[0]) begin
                        void'(job_len.pop_front());
                        bits_cnt  = 0;
                        done_pend = 1'b1;
                    end
                end
            end else begin
                check("x_idle", x_o, 1'b0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_ready", ready_o, 1'b1);
        check("rst_x", x_o, 1'b0);
        check("rst_xvalid", xvalid_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        #22 rst = 1'b0;
        @(negedge clk);

        // single pass and repeats
        cycle(1'b1, 8'b0000_0110, 4'd3, 4'd0);
        idle(6);
        cycle(1'b1, 8'b0000_0110, 4'd3, 4'd2);
        idle(12);

        // back-to-back with an ignored third load
        cycle(1'b1, 8'h0D, 4'd4, 4'd0);
        idle(1);
        cycle(1'b1, 8'h02, 4'd2, 4'd0);
        cycle(1'b1, 8'hFF, 4'd8, 4'd3);
        idle(8);

        // default length
        cycle(1'b1, 8'hA5, 4'd0, 4'd0);
        idle(10);
        cycle(1'b1, 8'hA5, 4'd9, 4'd0);
        idle(10);

        // asynchronous reset mid-job with a second job held
        cycle(1'b1, 8'hC3, 4'd8, 4'd0);
        idle(1);
        cycle(1'b1, 8'h5A, 4'd8, 4'd1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("midrst_x", x_o, 1'b0);
        check("midrst_xvalid", xvalid_o, 1'b0);
        check("midrst_ready", ready_o, 1'b1);
        check("midrst_done", done_o, 1'b0);
        @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        idle(20);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0)
                cycle(1'b1, 8'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)));
            else
                idle(1);
        end
        idle(200);

        vectors++;
        if (exp_bits.size() != 0 || job_len.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d bits left expected 0", exp_bits.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
